alu_wrapper: RTL and testbench
==============================

// Module: alu_wrapper
// PURPOSE
// - Self-stimulating 8-bit ALU test harness: internal 8-entry program ROM, sequencer, 8-bit ALU.
// - Streams each instruction as a 5-beat frame (operand A, operand B, opcode, result, flags).
// - data_type tags every beat, so a monitor or waveform can decode the stream without other inputs.
// - Top-level block: only clock and reset enter.
// PARAMETERS
// - LOOP  1  1: wrap from entry 7 to entry 0 forever; 0: after entry 7 flags beat, hold idle until reset.
// PORTS
// - clk        input   1  single clock; all state updates on rising edge.
// - rst        input   1  synchronous, active-high reset.
// - data_out   output  8  signed, registered; beat payload.
// - data_type  output  3  registered; beat tag:
//     0 idle/reset, 1 operand A, 2 operand B, 3 opcode (zero-extended), 4 result, 5 flags, 6-7 never driven.
// BEHAVIOUR
// - One clock; reset is synchronous and active-high.
// - Reset:
//     rst=1 at a rising edge gives data_out=0, data_type=0, entry index=0, beat=0.
//     Reset mid-frame aborts the frame; no partial-frame completion.
// - Sequencing:
//     First rising edge with rst=0 outputs entry 0 beat A (type 1).
//     Each later edge advances one beat: 1,2,3,4,5, then next entry.
//     Frame = 5 cycles; full pass = 40 cycles.
// - Wrap: after entry 7 flags beat, go to entry 0 type 1 if LOOP=1, else type 0/data 0 held.
// - Opcodes (3-bit):
//     0 ADD A+B, 1 SUB A-B, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL A by 1 (zero fill), 7 ASR A by 1 (sign fill).
// - Flags byte = {4'b0,N,Z,C,V}:
//     N = result[7]; Z = (result==0).
//     ADD: C = carry out of bit 7; V = signed overflow.
//     SUB: C = borrow (A<B unsigned); V = signed overflow.
//     Logic ops and NOT: C=0, V=0.
//     SHL: C=A[7], V=0.
//     ASR: C=A[0], V=0.
// - Result computed combinationally from ROM entry; only presented on beat 4. Result and flags are pure functions of the entry.
// - ROM {op,A,B} (unary ops B=0x00) -> result / flags:
//     0: ADD 0x64,0x32 -> 0x96 / 0x09
//     1: SUB 0x0A,0x14 -> 0xF6 / 0x0A
//     2: AND 0xF0,0x3C -> 0x30 / 0x00
//     3: OR  0xF0,0x0F -> 0xFF / 0x08
//     4: XOR 0xAA,0xAA -> 0x00 / 0x04
//     5: NOT 0x5A      -> 0xA5 / 0x08
//     6: SHL 0x81      -> 0x02 / 0x02
//     7: ASR 0x80      -> 0xC0 / 0x08
// - Outputs are glitch-free registers; no combinational path from rst to outputs.
// TESTING
// - Hold rst=1 5 cycles -> data_out=0x00, data_type=0 every cycle.
// - Release rst -> next 5 edges give (1,0x64),(2,0x32),(3,0x00),(4,0x96),(5,0x09).
// - Entry 1 frame -> (1,0x0A),(2,0x14),(3,0x01),(4,0xF6),(5,0x0A); check borrow flag C.
// - Run 40 cycles past reset; next beat -> (1,0x64) with LOOP=1; with LOOP=0 -> (0,0x00) held 20 cycles.
// - Assert rst during entry 3 beat 4 -> next edge (0,0x00); after release restarts at (1,0x64).
// - Check entries 4, 6, 7 frames: results 0x00, 0x02, 0xC0 and flags 0x04, 0x02, 0x08 respectively.

Source files
------------

// File: rtl/alu_wrapper.sv
// Self-stimulating 8-bit ALU harness: an 8-entry program ROM is walked by a
// beat sequencer and every instruction is streamed as a tagged 5-beat frame
// (operand A, operand B, opcode, result, flags) on data_out/data_type.
module alu_wrapper #(
  parameter bit LOOP = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic signed [7:0] data_out,
  output logic        [2:0] data_type
);

  // Beat encodings double as the data_type tag values.
  localparam logic [2:0] BEAT_IDLE = 3'd0;
  localparam logic [2:0] BEAT_A    = 3'd1;
  localparam logic [2:0] BEAT_B    = 3'd2;
  localparam logic [2:0] BEAT_OP   = 3'd3;
  localparam logic [2:0] BEAT_RES  = 3'd4;
  localparam logic [2:0] BEAT_FLG  = 3'd5;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_ASR = 3'd7;

  logic [2:0] entry_q, entry_d;
  logic [2:0] beat_q, beat_d;
  logic       done_q, done_d;
  logic [7:0] data_out_q, data_out_d;

  logic [2:0] rom_op;
  logic [7:0] rom_a, rom_b;
  logic [7:0] alu_res;
  logic       alu_c, alu_v;
  logic [8:0] sum9, diff9;
  logic [7:0] flags;

  // Next beat/entry; done_d latches the terminal idle state when not looping.
  always_comb begin
    entry_d = entry_q;
    beat_d  = beat_q;
    done_d  = done_q;
    if (!done_q) begin
      if (beat_q == BEAT_IDLE) begin
        beat_d = BEAT_A;
      end else if (beat_q == BEAT_FLG) begin
        if (entry_q == 3'd7 && !LOOP) begin
          beat_d  = BEAT_IDLE;
          entry_d = '0;
          done_d  = 1'b1;
        end else begin
          beat_d  = BEAT_A;
          entry_d = entry_q + 3'd1;
        end
      end else begin
        beat_d = beat_q + 3'd1;
      end
    end
  end

  // Program ROM, addressed by the upcoming entry so the output register
  // captures the payload of the beat being entered.
  always_comb begin
    rom_op = OP_ADD;
    rom_a  = '0;
    rom_b  = '0;
    case (entry_d)
      3'd0: begin rom_op = OP_ADD; rom_a = 8'h64; rom_b = 8'h32; end
      3'd1: begin rom_op = OP_SUB; rom_a = 8'h0A; rom_b = 8'h14; end
      3'd2: begin rom_op = OP_AND; rom_a = 8'hF0; rom_b = 8'h3C; end
      3'd3: begin rom_op = OP_OR;  rom_a = 8'hF0; rom_b = 8'h0F; end
      3'd4: begin rom_op = OP_XOR; rom_a = 8'hAA; rom_b = 8'hAA; end
      3'd5: begin rom_op = OP_NOT; rom_a = 8'h5A; rom_b = 8'h00; end
      3'd6: begin rom_op = OP_SHL; rom_a = 8'h81; rom_b = 8'h00; end
      default: begin rom_op = OP_ASR; rom_a = 8'h80; rom_b = 8'h00; end
    endcase
  end

  assign sum9  = {1'b0, rom_a} + {1'b0, rom_b};
  assign diff9 = {1'b0, rom_a} - {1'b0, rom_b};

  // ALU: result plus carry/borrow and signed overflow.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (rom_op)
      OP_ADD: begin
        alu_res = sum9[7:0];
        alu_c   = sum9[8];
        alu_v   = (rom_a[7] == rom_b[7]) && (sum9[7] != rom_a[7]);
      end
      OP_SUB: begin
        alu_res = diff9[7:0];
        alu_c   = diff9[8];
        alu_v   = (rom_a[7] != rom_b[7]) && (diff9[7] != rom_a[7]);
      end
      OP_AND: alu_res = rom_a & rom_b;
      OP_OR:  alu_res = rom_a | rom_b;
      OP_XOR: alu_res = rom_a ^ rom_b;
      OP_NOT: alu_res = ~rom_a;
      OP_SHL: begin
        alu_res = {rom_a[6:0], 1'b0};
        alu_c   = rom_a[7];
      end
      default: begin
        alu_res = {rom_a[7], rom_a[7:1]};
        alu_c   = rom_a[0];
      end
    endcase
  end

  assign flags = {4'b0000, alu_res[7], (alu_res == 8'h00), alu_c, alu_v};

  // Beat payload selection.
  always_comb begin
    data_out_d = '0;
    case (beat_d)
      BEAT_A:   data_out_d = rom_a;
      BEAT_B:   data_out_d = rom_b;
      BEAT_OP:  data_out_d = {5'b00000, rom_op};
      BEAT_RES: data_out_d = alu_res;
      BEAT_FLG: data_out_d = flags;
      default:  data_out_d = '0;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q    <= '0;
      beat_q     <= BEAT_IDLE;
      done_q     <= 1'b0;
      data_out_q <= '0;
    end else begin
      entry_q    <= entry_d;
      beat_q     <= beat_d;
      done_q     <= done_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out  = data_out_q;
  assign data_type = beat_q;

endmodule

// File: tb/tb_alu_wrapper.sv
// Directed bench for alu_wrapper: a looping and a non-looping instance share
// clock and reset; expected frames come from a hand-computed table.
module tb_alu_wrapper;

  logic       clk;
  logic       rst;
  logic [7:0] dout;
  logic [2:0] dtype;
  logic [7:0] dout_nl;
  logic [2:0] dtype_nl;

  int checks;
  int fails;

  logic [7:0] exp_a [8];
  logic [7:0] exp_b [8];
  logic [7:0] exp_r [8];
  logic [7:0] exp_f [8];

  alu_wrapper #(.LOOP(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_out  (dout),
    .data_type (dtype)
  );

  alu_wrapper #(.LOOP(1'b0)) dut_nl (
    .clk       (clk),
    .rst       (rst),
    .data_out  (dout_nl),
    .data_type (dtype_nl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected payload of beat b (1..5) of entry e.
  function automatic logic [7:0] exp_beat(input int e, input int b);
    case (b)
      1: return exp_a[e];
      2: return exp_b[e];
      3: return 8'(e);
      4: return exp_r[e];
      default: return exp_f[e];
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (dtype !== 3'd0 || dout !== 8'h00) begin
        fails++;
        $display("FAIL reset cyc%0d: got type=%0d data=%02h, want type=0 data=00", i, dtype, dout);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_entry0_entry1();
    logic [2:0] t [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    logic [7:0] d [10] = '{8'h64, 8'h32, 8'h00, 8'h96, 8'h09, 8'h0A, 8'h14, 8'h01, 8'hF6, 8'h0A};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (dtype !== t[i] || dout !== d[i]) begin
        fails++;
        $display("FAIL frame01 beat%0d: got type=%0d data=%02h, want type=%0d data=%02h",
                 i, dtype, dout, t[i], d[i]);
      end
    end
    // Borrow flag of entry 1 (SUB 0x0A-0x14).
    checks++;
    if (dout[1] !== 1'b1) begin
      fails++;
      $display("FAIL sub_borrow: got C=%0b, want C=1", dout[1]);
    end
  endtask

  task automatic test_full_pass_and_wrap();
    do_reset();
    for (int e = 0; e < 8; e++) begin
      for (int b = 1; b <= 5; b++) begin
        step();
        checks++;
        if (dtype !== 3'(b) || dout !== exp_beat(e, b)) begin
          fails++;
          $display("FAIL pass e%0d b%0d: got type=%0d data=%02h, want type=%0d data=%02h",
                   e, b, dtype, dout, b, exp_beat(e, b));
        end
        checks++;
        if (dtype_nl !== 3'(b) || dout_nl !== exp_beat(e, b)) begin
          fails++;
          $display("FAIL pass_noloop e%0d b%0d: got type=%0d data=%02h, want type=%0d data=%02h",
                   e, b, dtype_nl, dout_nl, b, exp_beat(e, b));
        end
      end
    end
    step();
    checks++;
    if (dtype !== 3'd1 || dout !== 8'h64) begin
      fails++;
      $display("FAIL wrap_loop: got type=%0d data=%02h, want type=1 data=64", dtype, dout);
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (dtype_nl !== 3'd0 || dout_nl !== 8'h00) begin
        fails++;
        $display("FAIL hold_noloop cyc%0d: got type=%0d data=%02h, want type=0 data=00",
                 i, dtype_nl, dout_nl);
      end
      step();
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    // Entry 3 beat 4 is the 19th beat after release.
    for (int i = 0; i < 19; i++) step();
    checks++;
    if (dtype !== 3'd4 || dout !== 8'hFF) begin
      fails++;
      $display("FAIL pre_abort: got type=%0d data=%02h, want type=4 data=FF", dtype, dout);
    end
    rst = 1'b1;
    step();
    checks++;
    if (dtype !== 3'd0 || dout !== 8'h00) begin
      fails++;
      $display("FAIL abort: got type=%0d data=%02h, want type=0 data=00", dtype, dout);
    end
    rst = 1'b0;
    step();
    checks++;
    if (dtype !== 3'd1 || dout !== 8'h64) begin
      fails++;
      $display("FAIL restart: got type=%0d data=%02h, want type=1 data=64", dtype, dout);
    end
    step();
    checks++;
    if (dtype !== 3'd2 || dout !== 8'h32) begin
      fails++;
      $display("FAIL restart_b: got type=%0d data=%02h, want type=2 data=32", dtype, dout);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst    = 1'b1;
    exp_a = '{8'h64, 8'h0A, 8'hF0, 8'hF0, 8'hAA, 8'h5A, 8'h81, 8'h80};
    exp_b = '{8'h32, 8'h14, 8'h3C, 8'h0F, 8'hAA, 8'h00, 8'h00, 8'h00};
    exp_r = '{8'h96, 8'hF6, 8'h30, 8'hFF, 8'h00, 8'hA5, 8'h02, 8'hC0};
    exp_f = '{8'h09, 8'h0A, 8'h00, 8'h08, 8'h04, 8'h08, 8'h02, 8'h08};
    test_reset();
    test_entry0_entry1();
    test_full_pass_and_wrap();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
